// File: rtl/spread_frame_ctrl.sv
// Frame sequencer for the Spread chip-spreader: preamble, sync word, then an
// upstream byte payload, one bit per ready/valid handshake, MSB first.
module spread_frame_ctrl #(
  parameter int          PREAMBLE_LEN = 16,
  parameter logic [31:0] SYNC_WORD    = 32'h1ACFFC1D,
  parameter int          SYNC_LEN     = 32,
  parameter int          LEN_W        = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_len,
  input  logic [7:0]       i_byte,
  input  logic             i_byte_valid,
  output logic             o_byte_ready,
  output logic             o_bit,
  output logic             o_bit_valid,
  input  logic             i_spread_ready,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_underrun
);

  localparam int MAXB  = (PREAMBLE_LEN > SYNC_LEN) ? PREAMBLE_LEN : SYNC_LEN;
  localparam int CNT_W = ($clog2(MAXB) < 3) ? 3 : $clog2(MAXB);
  // Sync bits left-justified so bit k of the sync field is always index 31-k.
  localparam logic [31:0] SYNC_AL = SYNC_WORD << (32 - SYNC_LEN);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    SYNC = 3'd2,
    PAY  = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   pos_q, pos_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   sent_q, sent_d;
  logic [LEN_W-1:0]   taken_q, taken_d;
  logic [7:0]         hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [7:0]         sh_q, sh_d;
  logic               cur_full_q, cur_full_d;
  logic               bit_q, bit_d;
  logic               vld_q, vld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               under_q, under_d;
  logic               bready_q, bready_d;
  logic               xfer_s, byte_xfer_s, need_byte_s;

  assign xfer_s      = vld_q & i_spread_ready;
  assign byte_xfer_s = bready_q & i_byte_valid;

  // Next-state and next-output computation for the whole frame sequencer.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    len_d       = len_q;
    sent_d      = sent_q;
    taken_d     = taken_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sh_d        = sh_q;
    cur_full_d  = cur_full_q;
    bit_d       = bit_q;
    vld_d       = vld_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    under_d     = under_q;
    need_byte_s = 1'b0;

    if (byte_xfer_s) begin
      hold_d      = i_byte;
      hold_full_d = 1'b1;
      taken_d     = taken_q + LEN_W'(1);
    end else begin
      hold_d      = hold_q;
    end

    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d     = PRE;
          len_d       = i_len;
          under_d     = 1'b0;
          pos_d       = '0;
          sent_d      = '0;
          taken_d     = '0;
          hold_full_d = 1'b0;
          cur_full_d  = 1'b0;
          bit_d       = 1'b1;
          vld_d       = 1'b1;
          busy_d      = 1'b1;
        end else begin
          vld_d       = 1'b0;
        end
      end
      PRE: begin
        if (xfer_s && (pos_q == CNT_W'(PREAMBLE_LEN - 1))) begin
          state_d = SYNC;
          pos_d   = '0;
          bit_d   = SYNC_AL[31];
        end else if (xfer_s) begin
          pos_d   = pos_q + CNT_W'(1);
          bit_d   = ~bit_q;
        end else begin
          pos_d   = pos_q;
        end
      end
      SYNC: begin
        if (xfer_s && (pos_q == CNT_W'(SYNC_LEN - 1))) begin
          pos_d = '0;
          if (len_q == '0) begin
            state_d = FIN;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d     = PAY;
            need_byte_s = 1'b1;
          end
        end else if (xfer_s) begin
          pos_d = pos_q + CNT_W'(1);
          bit_d = SYNC_AL[5'd30 - 5'(pos_q)];
        end else begin
          pos_d = pos_q;
        end
      end
      PAY: begin
        if (!cur_full_q) begin
          need_byte_s = 1'b1;
        end else if (xfer_s && (pos_q == CNT_W'(7))) begin
          sent_d     = sent_q + LEN_W'(1);
          pos_d      = '0;
          cur_full_d = 1'b0;
          if ((sent_q + LEN_W'(1)) == len_q) begin
            state_d = FIN;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            need_byte_s = 1'b1;
          end
        end else if (xfer_s) begin
          pos_d = pos_q + CNT_W'(1);
          sh_d  = {sh_q[6:0], 1'b0};
          bit_d = sh_q[6];
        end else begin
          pos_d = pos_q;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // A payload bit is due: move the prefetched byte in, or stall and flag it.
    if (need_byte_s && hold_full_q) begin
      sh_d        = hold_q;
      cur_full_d  = 1'b1;
      hold_full_d = 1'b0;
      bit_d       = hold_q[7];
      vld_d       = 1'b1;
      pos_d       = '0;
    end else if (need_byte_s) begin
      cur_full_d  = 1'b0;
      vld_d       = 1'b0;
      under_d     = under_q | ~byte_xfer_s;
    end else begin
      cur_full_d  = cur_full_d;
    end

    bready_d = ((state_d == SYNC) || (state_d == PAY)) && !hold_full_d && (taken_d != len_d);
  end

  // State and output registers; reset aborts any frame in progress.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      pos_q       <= '0;
      len_q       <= '0;
      sent_q      <= '0;
      taken_q     <= '0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      sh_q        <= 8'h00;
      cur_full_q  <= 1'b0;
      bit_q       <= 1'b0;
      vld_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      under_q     <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      len_q       <= len_d;
      sent_q      <= sent_d;
      taken_q     <= taken_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sh_q        <= sh_d;
      cur_full_q  <= cur_full_d;
      bit_q       <= bit_d;
      vld_q       <= vld_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      under_q     <= under_d;
      bready_q    <= bready_d;
    end
  end

  assign o_bit        = bit_q;
  assign o_bit_valid  = vld_q;
  assign o_byte_ready = bready_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_underrun   = under_q;

endmodule
